alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one 4-bit combinational ALU between two requesters. The ALU supports op codes 000 add, 001 sub, 010 not A, 011 and, 100 or, 101 xor, 110 zero, 111 equal (result is {3'b0, A==B}).
- Arbitrates round-robin and drives the ALU operands and op code.
- Captures the result and returns it to the granted requester over a valid/ready handshake.
- Sits between the ALU and its two command sources, e.g. the switch-input front end and the test sequencer.

Parameters:
- CNT_W, 8, width of the per-requester completed-operation counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester command valid; bit i belongs to requester i.
- req_ready  output  2  per-requester command accept; at most one bit high per cycle.
- req_op  input  6  {op1[2:0], op0[2:0]}.
- req_a  input  8  {a1[3:0], a0[3:0]}.
- req_b  input  8  {b1[3:0], b0[3:0]}.
- resp_valid  output  2  per-requester result valid.
- resp_ready  input  2  per-requester result accept.
- resp_data  output  4  result for whichever resp_valid bit is set.
- alu_op  output  3  op code to the shared ALU.
- alu_a  output  4  operand A to the shared ALU.
- alu_b  output  4  operand B to the shared ALU.
- alu_result  input  4  combinational ALU result.
- busy  output  1  high in any state other than IDLE.
- cnt0  output  CNT_W  completed operations for requester 0.
- cnt1  output  CNT_W  completed operations for requester 1.

Behaviour:
- States: IDLE, ISSUE, RESP. State is one-hot or encoded; the encoding is not observable.
- Reset (rst=1 at a clock edge) gives:
  - state=IDLE, prio pointer=0 (requester 0 preferred);
  - req_ready=0, resp_valid=0, resp_data=0;
  - alu_op/alu_a/alu_b=0, busy=0, cnt0=cnt1=0.
  - Reset mid-operation aborts the operation: no response is produced and counters clear.
- IDLE:
  - req_ready is combinational from req_valid and prio.
  - If only one requester is valid, that requester gets ready.
  - If both are valid, ready goes to requester==prio.
  - A handshake (valid&ready) latches op, a, b into internal command registers, latches the grant index, and moves to ISSUE.
  - No handshake: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - alu_op/alu_a/alu_b are driven from the command registers. They are registered outputs, holding their last values outside ISSUE.
  - At the end of the cycle, alu_result is captured into resp_data and the state moves to RESP.
  - req_ready=0.
- RESP:
  - resp_valid[grant]=1, the other bit 0; resp_data stable.
  - On resp_ready[grant]=1:
    - resp_valid clears next cycle;
    - the granted counter increments, wrapping at 2^CNT_W-1 to 0;
    - prio is set to ~grant;
    - state returns to IDLE.
  - resp_ready on the non-granted bit is ignored.
  - Back-pressure: RESP holds indefinitely, resp_data unchanged.
- Latency:
  - request handshake at cycle N;
  - ALU driven in N+1;
  - resp_valid high from N+2;
  - earliest next request accept at N+3 (after resp handshake at N+2).
- Throughput: one operation per 3 cycles maximum.
- Operand changes on req_* after acceptance have no effect.
- req_valid deasserted without handshake: no state change; a requester may withdraw.
- prio updates only on response completion, never on reset mid-flight or on idle cycles.
- Simultaneous valid from both with prio=1: requester 1 is served first, then requester 0 on the next IDLE.
- Result width is 4 bits. Add/sub wrap modulo 16 and no carry or flag is reported.

Test Plan:
- Single request, no contention:
  - stimulus: after reset, req0 op=000 a=4'h7 b=4'h5, resp_ready0=1.
  - required: req_ready0=1 in cycle 0; alu_a=7, alu_b=5, alu_op=000 in cycle 1; resp_valid=2'b01 with resp_data=4'hC in cycle 2; cnt0=1; prio=1.
- Contention, round-robin:
  - stimulus: both valid continuously, req0 op=001 a=3 b=5; req1 op=111 a=9 b=9.
  - required: req0 served first with resp_data=4'hE; req1 next with resp_data=4'h1; then req0 again. Grants alternate for 4 operations; cnt0=2, cnt1=2.
- Back-pressure:
  - stimulus: req1 op=010 a=4'hA, resp_ready1=0 for 5 cycles, then 1.
  - required: resp_valid1 and resp_data=4'h5 are held for all 6 cycles; busy=1 throughout; req_ready stays 0 even with req0 valid.
- Wrong-bit ready:
  - stimulus: granted requester 0, resp_ready=2'b10.
  - required: stays in RESP, cnt1 unchanged.
- Reset mid-operation:
  - stimulus: assert rst in ISSUE.
  - required: next cycle state=IDLE; all outputs zero; no resp_valid pulse; counters 0; prio=0.
- Counter wrap:
  - stimulus: CNT_W=2, run 5 ops on req0.
  - required: cnt0 sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin arbiter sharing one 4-bit ALU between two requesters
module alu_req_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [5:0]       req_op,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [3:0]       resp_data,
    output logic [2:0]       alu_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_result,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             grant_q, grant_d;
    logic [2:0]       op_q, op_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [3:0]       data_q, data_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic             sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    // The command registers double as the registered ALU drive, so they are
    // loaded at the request handshake and hold until the next one.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        grant_d    = grant_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        data_d     = data_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        sel        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid == 2'b11) begin
                    req_ready = prio_q ? 2'b10 : 2'b01;
                end else begin
                    req_ready = req_valid;
                end
                if (|req_ready) begin
                    sel     = req_ready[1];
                    grant_d = sel;
                    op_d    = sel ? req_op[5:3] : req_op[2:0];
                    a_d     = sel ? req_a[7:4]  : req_a[3:0];
                    b_d     = sel ? req_b[7:4]  : req_b[3:0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                data_d  = alu_result;
                state_d = RESP;
            end
            RESP: begin
                resp_valid = grant_q ? 2'b10 : 2'b01;
                if (resp_ready[grant_q]) begin
                    if (grant_q) begin
                        cnt1_d = cnt1_q + CNT_W'(1);
                    end else begin
                        cnt0_d = cnt0_q + CNT_W'(1);
                    end
                    prio_d  = ~grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign resp_data = data_q;
    assign busy      = (state_q != IDLE);
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed vector bench for alu_req_arbiter with a behavioural ALU
module tb_alu_req_arbiter;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [5:0]       req_op;
    logic [7:0]       req_a;
    logic [7:0]       req_b;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [3:0]       resp_data;
    logic [2:0]       alu_op;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_result;
    logic             busy;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt[2];

    alu_req_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = ~alu_a;
            3'b011:  alu_result = alu_a & alu_b;
            3'b100:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = alu_a ^ alu_b;
            3'b110:  alu_result = 4'h0;
            default: alu_result = {3'b000, alu_a == alu_b};
        endcase
    end

    typedef struct {
        int         r;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int r, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        if (r == 1) begin
            req_op[5:3] = op;
            req_a[7:4]  = a;
            req_b[7:4]  = b;
        end else begin
            req_op[2:0] = op;
            req_a[3:0]  = a;
            req_b[3:0]  = b;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        step();
        step();
        rst        = 1'b0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, " cnt0"}, int'(cnt0), exp_cnt[0]);
        chk({tag, " cnt1"}, int'(cnt1), exp_cnt[1]);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " resp_valid"}, int'(resp_valid), 0);
        chk({tag, " resp_data"},  int'(resp_data), 0);
        chk({tag, " alu_op"},     int'(alu_op), 0);
        chk({tag, " alu_a"},      int'(alu_a), 0);
        chk({tag, " alu_b"},      int'(alu_b), 0);
        chk({tag, " busy"},       int'(busy), 0);
        chk({tag, " req_ready"},  int'(req_ready), 0);
        chk_counts(tag);
    endtask

    // One uncontended operation: handshake, ALU issue, response, completion.
    task automatic single_op(input int r, input logic [2:0] op, input logic [3:0] a,
                             input logic [3:0] b, input logic [3:0] exp);
        logic [1:0] bit_r;
        bit_r     = (r == 1) ? 2'b10 : 2'b01;
        set_cmd(r, op, a, b);
        req_valid = bit_r;
        #1;
        chk("op req_ready", int'(req_ready), int'(bit_r));
        step();
        req_valid = 2'b00;
        req_a     = ~req_a;
        req_b     = ~req_b;
        req_op    = ~req_op;
        #1;
        chk("op alu_op", int'(alu_op), int'(op));
        chk("op alu_a", int'(alu_a), int'(a));
        chk("op alu_b", int'(alu_b), int'(b));
        chk("op issue busy", int'(busy), 1);
        chk("op issue resp_valid", int'(resp_valid), 0);
        step();
        chk("op resp_valid", int'(resp_valid), int'(bit_r));
        chk("op resp_data", int'(resp_data), int'(exp));
        resp_ready = bit_r;
        step();
        resp_ready = 2'b00;
        exp_cnt[r] = (exp_cnt[r] + 1) % (1 << CNT_W);
        chk("op done resp_valid", int'(resp_valid), 0);
        chk("op done busy", int'(busy), 0);
        chk_counts("op done");
    endtask

    initial begin
        vecs[0] = '{0, 3'b000, 4'h7, 4'h5, 4'hC};
        vecs[1] = '{1, 3'b001, 4'h3, 4'h5, 4'hE};
        vecs[2] = '{0, 3'b010, 4'hA, 4'h0, 4'h5};
        vecs[3] = '{1, 3'b011, 4'hC, 4'hA, 4'h8};
        vecs[4] = '{0, 3'b100, 4'hC, 4'h3, 4'hF};
        vecs[5] = '{1, 3'b101, 4'hF, 4'h5, 4'hA};
        vecs[6] = '{0, 3'b110, 4'h9, 4'h6, 4'h0};
        vecs[7] = '{1, 3'b111, 4'h9, 4'h9, 4'h1};
        vecs[8] = '{0, 3'b000, 4'hF, 4'h1, 4'h0};
        vecs[9] = '{1, 3'b111, 4'h3, 4'h4, 4'h0};

        do_reset();
        chk_idle_zero("reset");

        for (int i = 0; i < 10; i++) begin
            single_op(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Contention: both valid throughout, grants must alternate starting at 0.
        do_reset();
        set_cmd(0, 3'b001, 4'h3, 4'h5);
        set_cmd(1, 3'b111, 4'h9, 4'h9);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int g;
            g = k % 2;
            #1;
            chk("rr req_ready", int'(req_ready), (g == 1) ? 2 : 1);
            step();
            chk("rr issue req_ready", int'(req_ready), 0);
            step();
            chk("rr resp_valid", int'(resp_valid), (g == 1) ? 2 : 1);
            chk("rr resp_data", int'(resp_data), (g == 1) ? 4'h1 : 4'hE);
            chk("rr resp req_ready", int'(req_ready), 0);
            resp_ready = 2'b11;
            step();
            resp_ready = 2'b00;
            exp_cnt[g]++;
        end
        req_valid = 2'b00;
        chk_counts("rr");

        // Back-pressure on requester 1 while requester 0 waits.
        do_reset();
        set_cmd(1, 3'b010, 4'hA, 4'h0);
        req_valid = 2'b10;
        step();
        req_valid = 2'b01;
        set_cmd(0, 3'b000, 4'h1, 4'h1);
        step();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) resp_ready = 2'b10;
            #1;
            chk("bp resp_valid", int'(resp_valid), 2);
            chk("bp resp_data", int'(resp_data), 5);
            chk("bp busy", int'(busy), 1);
            chk("bp req_ready", int'(req_ready), 0);
            step();
        end
        resp_ready = 2'b00;
        exp_cnt[1] = 1;
        chk("bp next req_ready", int'(req_ready), 1);

        // Wrong-bit ready: requester 0 granted, only resp_ready[1] asserted.
        step();
        req_valid = 2'b00;
        step();
        resp_ready = 2'b10;
        step();
        step();
        chk("wb resp_valid", int'(resp_valid), 1);
        chk("wb resp_data", int'(resp_data), 2);
        chk("wb busy", int'(busy), 1);
        chk_counts("wb");
        resp_ready = 2'b01;
        step();
        resp_ready = 2'b00;
        exp_cnt[0] = 1;
        chk("wb done busy", int'(busy), 0);
        chk_counts("wb done");

        // Reset in ISSUE after one completion moved prio to 1.
        do_reset();
        single_op(0, 3'b000, 4'h2, 4'h3, 4'h5);
        set_cmd(0, 3'b100, 4'h6, 4'h1);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        chk("mid issue busy", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        chk_idle_zero("mid reset");
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mid no resp", int'(resp_valid), 0);
        end
        set_cmd(0, 3'b000, 4'h1, 4'h0);
        set_cmd(1, 3'b000, 4'h2, 4'h0);
        req_valid = 2'b11;
        #1;
        chk("mid prio", int'(req_ready), 1);
        req_valid = 2'b00;
        #1;

        // Counter wrap with CNT_W=2: 1,2,3,0,1.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            single_op(0, 3'b101, 4'(k), 4'h3, 4'(k) ^ 4'h3);
            chk("wrap cnt0", int'(cnt0), (k + 1) % 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
